// File: rtl/captura_jogada_pkg.sv
// Shared types and width helpers for the move-capture datapath.
package captura_jogada_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ESTAVEL = 2'd1,
        AVALIA  = 2'd2,
        SOLTA   = 2'd3
    } estado_t;

    // Index width for an N-entry one-hot vector (never below 1 bit)
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Debounce counter width: must hold the value DEBOUNCE
    function automatic int calc_cnt_w(input int d);
        return (d > 0) ? $clog2(d + 1) : 1;
    endfunction

endpackage

// File: rtl/codificador_onehot.sv
// One-hot to binary index encoder with a strict one-hot flag.
module codificador_onehot
    import captura_jogada_pkg::*;
#(
    parameter int N_POS = 9,
    parameter int IDX_W = calc_idx_w(N_POS)
) (
    input  logic [N_POS-1:0] vetor,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);

    logic visto;
    logic multiplo;

    // OR together the indices of set bits; flag whether exactly one bit is set
    always_comb begin
        idx      = '0;
        visto    = 1'b0;
        multiplo = 1'b0;
        for (int i = 0; i < N_POS; i++) begin
            if (vetor[i]) begin
                multiplo = multiplo | visto;
                visto    = 1'b1;
                idx      = idx | IDX_W'(i);
            end
        end
        is_onehot = visto && !multiplo;
    end

endmodule

// File: rtl/captura_jogada.sv
// Move capture for ultimate tic-tac-toe: debounce, validate and latch
// macro-board / micro-cell selections, and track cell occupancy.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ESPERA  | idle, waiting for a nonzero button sample while enabled
// ESTAVEL | candidate captured, counting identical samples
// AVALIA  | one cycle: validate candidate, pulse valid/invalid
// SOLTA   | waiting for all buttons released (no re-trigger on hold)
module captura_jogada
    import captura_jogada_pkg::*;
#(
    parameter int N_POS    = 9,
    parameter int DEBOUNCE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_POS-1:0] botoes,
    input  logic             zera,
    input  logic             habilita,
    input  logic             modo,
    input  logic [N_POS-1:0] fechado,
    input  logic             registra,
    output logic             tem_jogada,
    output logic             jogada_valida,
    output logic             jogada_invalida,
    output logic [N_POS-1:0] macro,
    output logic [N_POS-1:0] micro,
    output logic [N_POS-1:0] leds,
    output logic [1:0]       db_estado
);

    localparam int IDX_W = calc_idx_w(N_POS);
    localparam int CNT_W = calc_cnt_w(DEBOUNCE);
    localparam int OCC_W = calc_idx_w(N_POS * N_POS);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE - 1);

    estado_t                estado, estado_prox;
    logic [N_POS-1:0]       b_q;
    logic [N_POS-1:0]       amostra;
    logic [CNT_W-1:0]       cnt;
    logic [N_POS*N_POS-1:0] ocup;
    logic [IDX_W-1:0]       macro_idx, sel_idx;
    logic                   macro_onehot, sel_onehot;
    logic [OCC_W-1:0]       occ_addr;
    logic                   ok;
    logic                   avaliando;

    codificador_onehot #(.N_POS(N_POS), .IDX_W(IDX_W)) u_cod_macro (
        .vetor     (macro),
        .idx       (macro_idx),
        .is_onehot (macro_onehot)
    );

    codificador_onehot #(.N_POS(N_POS), .IDX_W(IDX_W)) u_cod_micro (
        .vetor     (amostra),
        .idx       (sel_idx),
        .is_onehot (sel_onehot)
    );

    // Register the raw buttons; every decision below uses this sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) b_q <= '0;
        else       b_q <= botoes;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= ESPERA;
        else       estado <= estado_prox;
    end

    // Next state; zera overrides everything and parks in SOLTA until release
    always_comb begin
        estado_prox = estado;
        case (estado)
            ESPERA:  if (habilita && b_q != '0) estado_prox = ESTAVEL;
            ESTAVEL: begin
                if (!habilita || b_q != amostra) estado_prox = ESPERA;
                else if (cnt == CNT_FIM)         estado_prox = AVALIA;
            end
            AVALIA:  estado_prox = SOLTA;
            SOLTA:   if (b_q == '0) estado_prox = ESPERA;
            default: estado_prox = ESPERA;
        endcase
        if (zera) estado_prox = SOLTA;
    end

    // Candidate capture and debounce counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            amostra <= '0;
            cnt     <= '0;
        end else if (estado == ESPERA) begin
            amostra <= b_q;
            cnt     <= '0;
        end else if (estado == ESTAVEL) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Move validation against the current (pre-write) occupancy table
    always_comb begin
        occ_addr = OCC_W'(macro_idx) * OCC_W'(N_POS) + OCC_W'(sel_idx);
        if (modo) ok = sel_onehot && macro_onehot && !ocup[occ_addr];
        else      ok = sel_onehot && ((amostra & fechado) == '0);
    end

    assign avaliando       = (estado == AVALIA) && !zera;
    assign jogada_valida   = avaliando && ok;
    assign jogada_invalida = avaliando && !ok;
    assign tem_jogada      = (estado != ESPERA);
    assign leds            = b_q;
    assign db_estado       = estado;

    // Selection latches and occupancy table; zera clears and wins over registra
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            macro <= '0;
            micro <= '0;
            ocup  <= '0;
        end else if (zera) begin
            macro <= '0;
            micro <= '0;
            ocup  <= '0;
        end else begin
            if (jogada_valida) begin
                if (modo) micro <= amostra;
                else      macro <= amostra;
            end
            if (registra) begin
                for (int i = 0; i < N_POS; i++)
                    for (int j = 0; j < N_POS; j++)
                        if (macro[i] && micro[j]) ocup[i*N_POS + j] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_captura_jogada.sv
// Self-checking bench for captura_jogada (N_POS=9, DEBOUNCE=4).
module tb_captura_jogada;

    localparam int N = 9;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] botoes, fechado;
    logic         zera, habilita, modo, registra;
    logic         tem_jogada, jogada_valida, jogada_invalida;
    logic [N-1:0] macro, micro, leds;
    logic [1:0]   db_estado;

    captura_jogada #(.N_POS(N), .DEBOUNCE(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .zera            (zera),
        .habilita        (habilita),
        .modo            (modo),
        .fechado         (fechado),
        .registra        (registra),
        .tem_jogada      (tem_jogada),
        .jogada_valida   (jogada_valida),
        .jogada_invalida (jogada_invalida),
        .macro           (macro),
        .micro           (micro),
        .leds            (leds),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int n_val = 0;
    int n_inv = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Reference model: a press is judged once the same nonzero sample has been
    // seen on DEBOUNCE+1 consecutive enabled edges, then release is awaited.
    logic [N-1:0] m_bq, m_cand, m_macro, m_micro;
    bit           m_ocup [N][N];
    int           m_run;
    bit           m_eval, m_solta;

    function automatic int idx_de(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit modelo_ok();
        if ($countones(m_cand) != 1) return 1'b0;
        if (!modo) return (m_cand & fechado) == '0;
        return (m_macro != '0) && !m_ocup[idx_de(m_macro)][idx_de(m_cand)];
    endfunction

    task automatic limpa_ocup();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m_ocup[i][j] = 1'b0;
    endtask

    task automatic modelo_reset();
        m_bq = '0; m_cand = '0; m_macro = '0; m_micro = '0;
        m_run = 0; m_eval = 1'b0; m_solta = 1'b0;
        limpa_ocup();
    endtask

    task automatic modelo_passo();
        bit aceita;
        aceita = modelo_ok();
        if (zera) begin
            m_macro = '0; m_micro = '0; limpa_ocup();
            m_eval = 1'b0; m_solta = 1'b1; m_run = 0;
        end else begin
            if (registra && m_macro != '0 && m_micro != '0)
                m_ocup[idx_de(m_macro)][idx_de(m_micro)] = 1'b1;
            if (m_eval) begin
                if (aceita) begin
                    if (modo) m_micro = m_cand;
                    else      m_macro = m_cand;
                end
                m_eval = 1'b0; m_solta = 1'b1;
            end else if (m_solta) begin
                if (m_bq == '0) m_solta = 1'b0;
            end else if (m_run == 0) begin
                if (habilita && m_bq != '0) begin m_run = 1; m_cand = m_bq; end
            end else if (!habilita || m_bq != m_cand) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == D + 1) begin m_run = 0; m_eval = 1'b1; end
            end
        end
        m_bq = botoes;
    endtask

    task automatic confere();
        bit pv, pi;
        logic [1:0] e_est;
        pv = m_eval && !zera && modelo_ok();
        pi = m_eval && !zera && !modelo_ok();
        e_est = m_eval ? 2'd2 : m_solta ? 2'd3 : (m_run > 0) ? 2'd1 : 2'd0;
        verifica("leds",       leds,            m_bq);
        verifica("macro",      macro,           m_macro);
        verifica("micro",      micro,           m_micro);
        verifica("tem_jogada", tem_jogada,      (m_eval || m_solta || m_run > 0));
        verifica("valida",     jogada_valida,   pv);
        verifica("invalida",   jogada_invalida, pi);
        verifica("db_estado",  db_estado,       e_est);
        if (jogada_valida)   n_val++;
        if (jogada_invalida) n_inv++;
    endtask

    task automatic ciclo();
        @(posedge clock);
        modelo_passo();
        @(negedge clock);
        confere();
    endtask

    task automatic segura(input logic [N-1:0] b, input int n);
        botoes = b;
        repeat (n) ciclo();
    endtask

    task automatic zera_cont();
        n_val = 0; n_inv = 0;
    endtask

    initial begin
        reset = 1'b1; botoes = '0; fechado = '0;
        zera = 1'b0; habilita = 1'b0; modo = 1'b0; registra = 1'b0;
        modelo_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        confere();

        // Reset asserted mid-debounce
        habilita = 1'b1; zera_cont();
        segura(9'h010, 3);
        verifica("t1_pre_estado", db_estado, 2'd1);
        reset = 1'b1;
        #1;
        modelo_reset();
        verifica("t1_rst_estado", db_estado, 2'd0);
        verifica("t1_rst_tem", tem_jogada, 1'b0);
        verifica("t1_rst_leds", leds, 9'h000);
        botoes = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        confere();
        verifica("t1_pulsos", n_val + n_inv, 0);

        // Accepted macro selection
        zera_cont();
        segura(9'h010, 8);
        verifica("t2_val", n_val, 1);
        verifica("t2_macro", macro, 9'h010);
        segura(9'h000, 2);
        verifica("t2_espera", db_estado, 2'd0);

        // Bouncing never reaches evaluation
        zera_cont();
        for (int k = 0; k < 10; k++) begin
            segura(9'h010, 2);
            segura(9'h000, 2);
        end
        verifica("t3_pulsos", n_val + n_inv, 0);
        verifica("t3_macro", macro, 9'h010);

        // Non one-hot and closed board rejected
        zera_cont();
        segura(9'h003, 8);
        segura(9'h000, 2);
        verifica("t4_inv_multi", n_inv, 1);
        verifica("t4_macro", macro, 9'h010);
        zera_cont();
        fechado = 9'h010;
        segura(9'h010, 8);
        segura(9'h000, 2);
        fechado = '0;
        verifica("t4_inv_fechado", n_inv, 1);
        verifica("t4_val_fechado", n_val, 0);

        // Occupancy: register cell 36, then re-selecting it is rejected
        modo = 1'b1; zera_cont();
        segura(9'h001, 8);
        segura(9'h000, 2);
        verifica("t5_val_micro", n_val, 1);
        verifica("t5_micro", micro, 9'h001);
        registra = 1'b1; ciclo(); registra = 1'b0;
        zera_cont();
        segura(9'h001, 8);
        segura(9'h000, 2);
        verifica("t5_inv_ocup", n_inv, 1);
        zera_cont();
        segura(9'h002, 8);
        segura(9'h000, 2);
        verifica("t5_val_livre", n_val, 1);
        verifica("t5_micro2", micro, 9'h002);

        // zera mid-debounce clears everything and waits for release
        modo = 1'b0; zera_cont();
        segura(9'h002, 3);
        zera = 1'b1; ciclo(); zera = 1'b0;
        verifica("t6_macro", macro, 9'h000);
        verifica("t6_micro", micro, 9'h000);
        verifica("t6_estado", db_estado, 2'd3);
        segura(9'h002, 6);
        verifica("t6_segura", db_estado, 2'd3);
        verifica("t6_pulsos", n_val + n_inv, 0);
        segura(9'h000, 2);
        verifica("t6_espera", db_estado, 2'd0);
        segura(9'h010, 8); segura(9'h000, 2);
        modo = 1'b1;
        segura(9'h001, 8); segura(9'h000, 2);
        verifica("t6_ocup_limpa", n_val, 2);

        // Randomised segments
        for (int s = 0; s < 400; s++) begin
            int r, len;
            logic [N-1:0] v;
            r = $urandom_range(0, 9);
            if (r == 6)      v = '0;
            else if (r == 7) v = N'($urandom);
            else             v = N'(1) << $urandom_range(0, N - 1);
            len      = $urandom_range(1, 10);
            habilita = ($urandom_range(0, 9) != 0);
            modo     = $urandom_range(0, 1) != 0;
            fechado  = N'($urandom & $urandom & $urandom);
            botoes   = v;
            for (int c = 0; c < len; c++) begin
                registra = ($urandom_range(0, 99) < 15);
                zera     = ($urandom_range(0, 99) < 2);
                ciclo();
            end
            zera = 1'b0; registra = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
